// File: rtl/demux8_stream.sv
// ---------------------------------------------------------------------------
// demux8_stream
//   1:8 valid/ready stream demultiplexer. Each accepted input word is routed
//   to exactly one of eight consumers, chosen by in_sel at accept time, and
//   is presented from a registered output stage (shared data bus plus a
//   one-hot valid vector).
//
// Parameters
//   N          data width of in_data and out_data
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    input word
//   in_sel     destination channel 0..7 for in_data
//   in_valid   producer presents a word
//   in_ready   block can accept a word this cycle
//   out_data   shared registered data bus
//   out_valid  one-hot valid, bit k = word pending for channel k
//   out_ready  bit k = channel k consumer accepts this cycle
//
// Build option
//   DEMUX8_STREAM_SKID_EN  adds a second (skid) entry and makes in_ready a
//                          register with no combinational path from
//                          out_ready. Undefined: single holding register
//                          with combinational in_ready.
// ---------------------------------------------------------------------------
module demux8_stream #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic [2:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ready
);

    // One-hot decode of a channel number.
    function automatic logic [7:0] onehot8(input logic [2:0] sel);
        onehot8 = 8'h01 << sel;
    endfunction

    logic [N-1:0] data_q, data_d;
    logic [2:0]   sel_q, sel_d;
    logic         hold_full_s;
    logic         accept_s;
    logic         drain_s;

    // Only the selected channel's ready can drain the holding register.
    assign drain_s  = hold_full_s && out_ready[sel_q];
    assign accept_s = in_valid && in_ready;

`ifdef DEMUX8_STREAM_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] skid_data_q, skid_data_d;
    logic [2:0]   skid_sel_q, skid_sel_d;
    logic         in_ready_q, in_ready_d;

    assign hold_full_s = (state_q != ST_EMPTY);
    // in_ready_q is left at 1 through reset so the first cycle after release
    // already accepts; rst gating keeps it low while reset is held.
    assign in_ready    = in_ready_q && !rst;

    // Next-state logic: the holding register always carries the oldest word,
    // the skid register the younger one, so channel order is FIFO.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sel_d       = sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    data_d  = in_data;
                    sel_d   = in_sel;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (drain_s && accept_s) begin
                    data_d  = in_data;
                    sel_d   = in_sel;
                    state_d = ST_ONE;
                end else if (drain_s) begin
                    state_d = ST_EMPTY;
                end else if (accept_s) begin
                    skid_data_d = in_data;
                    skid_sel_d  = in_sel;
                    state_d     = ST_TWO;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so no accept can coincide.
                if (drain_s) begin
                    data_d  = skid_data_q;
                    sel_d   = skid_sel_q;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    // State and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            data_q      <= '0;
            sel_q       <= 3'd0;
            skid_data_q <= '0;
            skid_sel_q  <= 3'd0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
        end
    end

`else

    logic full_q, full_d;

    assign hold_full_s = full_q;
    // A full register can still accept when its word drains on this edge.
    assign in_ready    = !rst && (!full_q || out_ready[sel_q]);

    // Next-state logic for the single holding register.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        sel_d  = sel_q;
        if (accept_s) begin
            data_d = in_data;
            sel_d  = in_sel;
            full_d = 1'b1;
        end else if (drain_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // State and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            sel_q  <= 3'd0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end

`endif

    assign out_valid = hold_full_s ? onehot8(sel_q) : 8'h00;
    assign out_data  = data_q;

endmodule

// File: tb/tb_demux8_stream.sv
// ---------------------------------------------------------------------------
// tb_demux8_stream
//   Directed, table-driven bench for demux8_stream with N=8. Inputs change
//   1 time unit after the rising edge; outputs are compared 1 unit later,
//   so registered outputs show the state after the previous edge and
//   in_ready reflects the inputs of the current cycle. The vector table
//   holds expectations for the default (single register) build; the reset
//   sequence covers both builds.
// ---------------------------------------------------------------------------
module tb_demux8_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [7:0] out_valid;
    logic [7:0] out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    demux8_stream #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Drain monitor: records what each channel actually receives.
    logic mon_en = 1'b0;
    int   drain_cnt [8];
    logic [7:0] drain_data [8];
    initial begin
        for (int j = 0; j < 8; j++) begin
            drain_cnt[j]  = 0;
            drain_data[j] = 8'h00;
        end
    end
    always @(posedge clk) begin
        if (mon_en && !rst) begin
            for (int j = 0; j < 8; j++) begin
                if (out_valid[j] && out_ready[j]) begin
                    drain_cnt[j]  = drain_cnt[j] + 1;
                    drain_data[j] = out_data;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] s,
                         input logic [7:0] d, input logic [7:0] ordy);
        rst       = r;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] sel;
        logic [7:0] data;
        logic [7:0] ordy;
        logic [7:0] exp_ov;
        logic [7:0] exp_od;
        logic       exp_ir;
    } vec_t;

    vec_t vecs [18];

    initial begin
        //            rst   vld   sel   data   ordy   exp_ov exp_od exp_ir
        // reset, held for two edges
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1};
        // single word A5 to channel 5
        vecs[3]  = '{1'b0, 1'b1, 3'd5, 8'hA5, 8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 8'h20, 8'hA5, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'hA5, 1'b1};
        // backpressure: 3C to ch2 stalled 4 cycles, next word 77 to ch4 held
        vecs[6]  = '{1'b0, 1'b1, 3'd2, 8'h3C, 8'h00, 8'h00, 8'hA5, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 3'd4, 8'h77, 8'h00, 8'h04, 8'h3C, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'd4, 8'h77, 8'h00, 8'h04, 8'h3C, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd4, 8'h77, 8'h00, 8'h04, 8'h3C, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'd4, 8'h77, 8'h00, 8'h04, 8'h3C, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'd4, 8'h77, 8'h04, 8'h04, 8'h3C, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h10, 8'h77, 1'b0};
        // drain 77 while loading E7 for ch7; non-selected readies ignored
        vecs[13] = '{1'b0, 1'b1, 3'd7, 8'hE7, 8'h10, 8'h10, 8'h77, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h7F, 8'h80, 8'hE7, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h7F, 8'h80, 8'hE7, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h80, 8'h80, 8'hE7, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hE7, 1'b1};

        drive(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);

        for (int i = 0; i < 18; i++) begin
            next_cycle();
            drive(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d out_valid", i), {24'h0, out_valid}, {24'h0, vecs[i].exp_ov});
            check($sformatf("vec%0d out_data", i),  {24'h0, out_data},  {24'h0, vecs[i].exp_od});
            check($sformatf("vec%0d in_ready", i),  {31'h0, in_ready},  {31'h0, vecs[i].exp_ir});
        end

        // Streaming sweep: word k to channel k, all consumers ready.
        mon_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            drive(1'b0, 1'b1, k[2:0], k[7:0], 8'hFF);
            #1;
            check($sformatf("sweep%0d in_ready", k), {31'h0, in_ready}, 32'd1);
            check($sformatf("sweep%0d out_valid", k), {24'h0, out_valid},
                  (k == 0) ? 32'h0 : (32'h1 << (k - 1)));
            check($sformatf("sweep%0d out_data", k), {24'h0, out_data},
                  (k == 0) ? 32'hE7 : (k - 1));
        end
        next_cycle();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
        #1;
        check("sweep last out_valid", {24'h0, out_valid}, 32'h80);
        check("sweep last out_data",  {24'h0, out_data},  32'h07);
        next_cycle();
        check("sweep empty out_valid", {24'h0, out_valid}, 32'h00);
        mon_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("sweep ch%0d drains", j), drain_cnt[j], 32'd1);
            check($sformatf("sweep ch%0d data", j), {24'h0, drain_data[j]}, j);
        end

        // Reset mid-operation discards pending words.
        drive(1'b0, 1'b1, 3'd1, 8'h11, 8'h00);
        #1;
        check("rstmid accept ch1 in_ready", {31'h0, in_ready}, 32'd1);
        next_cycle();
`ifdef DEMUX8_STREAM_SKID_EN
        drive(1'b0, 1'b1, 3'd6, 8'h66, 8'h00);
        #1;
        check("rstmid accept ch6 in_ready", {31'h0, in_ready}, 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        #1;
        check("rstmid two in_ready", {31'h0, in_ready}, 32'd0);
`else
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        #1;
`endif
        check("rstmid pending out_valid", {24'h0, out_valid}, 32'h02);
        check("rstmid pending out_data",  {24'h0, out_data},  32'h11);
        rst = 1'b1;
        #1;
        check("rstmid in_ready during rst", {31'h0, in_ready}, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("rstmid cleared out_valid", {24'h0, out_valid}, 32'h00);
        check("rstmid cleared out_data",  {24'h0, out_data},  32'h00);
        check("rstmid in_ready after rst", {31'h0, in_ready}, 32'd1);
        next_cycle();
        check("rstmid no stale word", {24'h0, out_valid}, 32'h00);
        drive(1'b0, 1'b1, 3'd3, 8'h33, 8'h08);
        #1;
        check("post rst in_ready", {31'h0, in_ready}, 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h08);
        #1;
        check("post rst out_valid", {24'h0, out_valid}, 32'h08);
        check("post rst out_data",  {24'h0, out_data},  32'h33);
        next_cycle();
        check("post rst drained", {24'h0, out_valid}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
